serial_shift_sender: RTL and testbench

- Parallel-to-serial sequencer that drives a chain of DM74LS194-style universal shift registers held in shift-right mode (S1S0=01).
- Captures a parallel word on start and emits it MSB first on s_dat, with a divided serial clock s_clk and a downstream active-low clear s_clrn.
- Sits directly upstream of the shift-register chain: s_clk goes to the register clk, s_dat to SR of the first device, s_clrn to clear.
- Used for the board LED and 7-segment shift chains; handshakes with the display logic through start/busy/done.

---
 rtl/serial_shift_sender.sv | 108 ++++++++++
 tb/tb_serial_shift_sender.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_shift_sender.sv
// Parallel-to-serial sequencer for a chain of '194-style shift registers in shift-right mode.
// Emits a captured word MSB first on s_dat with a divided s_clk, plus a downstream clear pulse.
module serial_shift_sender #(
  parameter int DATA_BITS = 16,
  parameter int CLK_DIV   = 2
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 clr_req,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 s_clk,
  output logic                 s_dat,
  output logic                 s_clrn,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, CLRP, SETUP, HIGH, DONE} state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 s_clk_d, s_dat_d, s_clrn_d, busy_d, done_d;
  logic                 div_last;

  assign div_last = (div_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d  = data_in;
          bit_cnt_d = '0;
          div_d     = '0;
          state_d   = SETUP;
        end else if (clr_req) begin
          div_d   = '0;
          state_d = CLRP;
        end
      end
      CLRP, SETUP: begin
        if (div_last) begin
          div_d   = '0;
          state_d = (state_q == CLRP) ? IDLE : HIGH;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      HIGH: begin
        if (div_last) begin
          div_d     = '0;
          shadow_d  = {shadow_q[DATA_BITS-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          state_d   = (bit_cnt_q == LAST_BIT) ? DONE : SETUP;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land registered with the state change.
  always_comb begin
    s_clk_d  = (state_d == HIGH);
    s_dat_d  = ((state_d == SETUP) || (state_d == HIGH)) ? shadow_d[DATA_BITS-1] : 1'b0;
    s_clrn_d = (state_d != CLRP);
    busy_d   = (state_d == CLRP) || (state_d == SETUP) || (state_d == HIGH);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      s_clk     <= 1'b0;
      s_dat     <= 1'b0;
      s_clrn    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      s_clk     <= s_clk_d;
      s_dat     <= s_dat_d;
      s_clrn    <= s_clrn_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_shift_sender.sv
// Directed bench for serial_shift_sender: expected bits are queued at start and popped on s_clk rises.
module tb_serial_shift_sender;

  localparam int DATA_BITS = 8;
  localparam int CLK_DIV   = 2;

  logic                 clk = 1'b0;
  logic                 clear, start, clr_req;
  logic [DATA_BITS-1:0] data_in;
  logic                 s_clk, s_dat, s_clrn, busy, done;

  int   checks = 0, failures = 0;
  int   busy_cycles, done_cnt, clrn_low, clrn_busy, rise_cnt;
  logic prev_sclk = 1'b0;
  logic [3:0] chain1 = '0, chain2 = '0;
  logic exp_q[$];

  always #5 clk = ~clk;

  serial_shift_sender #(.DATA_BITS(DATA_BITS), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .clear(clear), .start(start), .clr_req(clr_req), .data_in(data_in),
    .s_clk(s_clk), .s_dat(s_dat), .s_clrn(s_clrn), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DATA_BITS-1:0] w);
    for (int i = DATA_BITS - 1; i >= 0; i--) exp_q.push_back(w[i]);
    $display("txn queued word=%02h", w);
  endtask

  task automatic clr_stats();
    busy_cycles = 0; done_cnt = 0; clrn_low = 0; clrn_busy = 0; rise_cnt = 0;
  endtask

  // One clk cycle; samples at the falling edge and models two '194 devices in shift-right mode.
  task automatic tick();
    logic e;
    @(negedge clk);
    if (busy) busy_cycles++;
    if (done) begin
      done_cnt++;
      chk("done_busy_low", busy, 1'b0);
    end
    if (!s_clrn) begin
      clrn_low++;
      if (busy) clrn_busy++;
      chain1 = '0;
      chain2 = '0;
    end else if (s_clk && !prev_sclk) begin
      rise_cnt++;
      chain2 = {chain1[0], chain2[3:1]};
      chain1 = {s_dat, chain1[3:1]};
      chk("sclk_rise_expected", (exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sdat_bit", s_dat, e);
      end
    end
    prev_sclk = s_clk;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done_timeout"}, (done_cnt != d0), 1'b1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_s_clk"}, s_clk, 1'b0);
    chk({tag, "_s_dat"}, s_dat, 1'b0);
    chk({tag, "_s_clrn"}, s_clrn, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    clear = 1'b0; start = 1'b0; clr_req = 1'b0; data_in = '0;
    clr_stats();
    repeat (3) tick();
    check_idle("in_reset");
    clear = 1'b1;
    tick();
    check_idle("after_reset");

    // Basic transfer of A5.
    clr_stats();
    data_in = 8'hA5; start = 1'b1; push_word(8'hA5);
    tick();
    start = 1'b0;
    wait_done("basic", 100);
    repeat (2) tick();
    chk("basic_busy_cycles", busy_cycles, 2 * CLK_DIV * DATA_BITS);
    chk("basic_done_cycles", done_cnt, 1);
    chk("basic_rises", rise_cnt, DATA_BITS);
    chk("chain1_qa_qd", chain1, 4'b1010);
    chk("chain2_qa_qd", chain2, 4'b0101);
    $display("txn basic busy=%0d done=%0d rises=%0d", busy_cycles, done_cnt, rise_cnt);

    // start held high, data_in changed after acceptance; back-to-back second word uses FF.
    clr_stats();
    data_in = 8'hA5; start = 1'b1; push_word(8'hA5);
    tick();
    data_in = 8'hFF;
    wait_done("hold1", 100);
    chk("hold1_busy_cycles", busy_cycles, 2 * CLK_DIV * DATA_BITS);
    push_word(8'hFF);
    clr_stats();
    for (int i = 0; i < 3 && !busy; i++) tick();
    chk("hold2_restarted", busy, 1'b1);
    wait_done("hold2", 100);
    start = 1'b0;
    tick();
    chk("hold2_rises", rise_cnt, DATA_BITS);
    chk("hold2_done_cycles", done_cnt, 1);
    $display("txn back_to_back rises=%0d", rise_cnt);

    // Downstream clear pulse.
    clr_stats();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (6) tick();
    chk("clrp_low_cycles", clrn_low, CLK_DIV);
    chk("clrp_busy_cycles", clrn_busy, CLK_DIV);
    chk("clrp_no_done", done_cnt, 0);
    chk("clrp_chain_cleared", {chain1, chain2}, 8'h00);
    $display("txn clear_pulse low=%0d", clrn_low);

    // start beats clr_req in the same cycle.
    clr_stats();
    data_in = 8'h5A; start = 1'b1; clr_req = 1'b1; push_word(8'h5A);
    tick();
    start = 1'b0; clr_req = 1'b0;
    wait_done("prio", 100);
    tick();
    chk("prio_no_clear", clrn_low, 0);
    chk("prio_rises", rise_cnt, DATA_BITS);

    // Asynchronous reset after the third s_clk rise.
    clr_stats();
    data_in = 8'hC3; start = 1'b1; push_word(8'hC3);
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && rise_cnt < 3; i++) tick();
    chk("abort_reached_rise3", rise_cnt, 3);
    clear = 1'b0;
    #1;
    check_idle("abort_immediate");
    exp_q.delete();
    repeat (3) tick();
    chk("abort_no_done", done_cnt, 0);
    clear = 1'b1;
    tick();
    $display("txn aborted after rise=%0d", rise_cnt);

    clr_stats();
    data_in = 8'h3C; start = 1'b1; push_word(8'h3C);
    tick();
    start = 1'b0;
    wait_done("post_abort", 100);
    tick();
    chk("post_abort_rises", rise_cnt, DATA_BITS);
    chk("post_abort_busy_cycles", busy_cycles, 2 * CLK_DIV * DATA_BITS);
    chk("queue_drained", exp_q.size(), 0);
    $display("txn post_abort rises=%0d", rise_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
